lsu_riscv: RTL

LSU_RISCV -- requirements
Module: lsu_riscv

---
 rtl/lsu_riscv.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lsu_riscv.sv
// RISC-V load/store unit: one outstanding access over a req/gnt/rvalid memory port.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_riscv (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [2:0]  size_reg;
    logic [31:0] addr_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;

    logic [2:0]  size_norm;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        misaligned_req;
    logic        issue;
    logic        misalign_flag;

    // Unsupported size codes collapse to a signed byte access.
    always_comb begin
        case (lsu_size_i)
            LDST_H, LDST_W, LDST_BU, LDST_HU: size_norm = lsu_size_i;
            default:                          size_norm = LDST_B;
        endcase
    end

    always_comb begin
        be_next    = 4'b0001 << lsu_addr_i[1:0];
        wdata_next = {4{lsu_data_i[7:0]}};
        case (size_norm)
            LDST_H, LDST_HU: begin
                be_next    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_next = {2{lsu_data_i[15:0]}};
            end
            LDST_W: begin
                be_next    = 4'b1111;
                wdata_next = lsu_data_i;
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned_req = (((size_norm == LDST_H) || (size_norm == LDST_HU)) && lsu_addr_i[0])
                          || ((size_norm == LDST_W) && (lsu_addr_i[1:0] != 2'b00));
`else
    assign misaligned_req = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        issue         = 1'b0;
        misalign_flag = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (lsu_req_i) begin
                    if (misaligned_req) begin
                        misalign_flag = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (data_gnt_i) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (data_rvalid_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Byte enables and replicated store data are captured at issue so the
    // memory-side outputs stay stable however long the grant takes.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            we_reg    <= 1'b0;
            size_reg  <= 3'b000;
            addr_reg  <= 32'd0;
            be_reg    <= 4'd0;
            wdata_reg <= 32'd0;
        end else if (issue) begin
            we_reg    <= lsu_we_i;
            size_reg  <= size_norm;
            addr_reg  <= lsu_addr_i;
            be_reg    <= be_next;
            wdata_reg <= wdata_next;
        end
    end

    assign data_req_o      = (state_reg == ST_REQ);
    assign data_we_o       = we_reg;
    assign data_be_o       = be_reg;
    assign data_addr_o     = {addr_reg[31:2], 2'b00};
    assign data_wdata_o    = wdata_reg;
    assign lsu_misalign_o  = misalign_flag;
    assign lsu_stall_req_o = lsu_req_i && !((state_reg == ST_RESP) && data_rvalid_i) && !misalign_flag;

    logic [7:0]  lane_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = data_rdata_i[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane_byte[addr_reg[1:0]];
    assign sel_half = addr_reg[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

    always_comb begin
        case (size_reg)
            LDST_H:  lsu_data_o = {{16{sel_half[15]}}, sel_half};
            LDST_HU: lsu_data_o = {16'd0, sel_half};
            LDST_W:  lsu_data_o = data_rdata_i;
            LDST_BU: lsu_data_o = {24'd0, sel_byte};
            default: lsu_data_o = {{24{sel_byte[7]}}, sel_byte};
        endcase
    end

endmodule
